imem_rom_ctl: RTL and testbench

Parametrised instruction memory for the single-cycle RISC-V datapath. It replaces the fixed combinational case-table ROM with a writable word array and a registered, handshaked fetch port. A loader port lets the bench or a boot block program the array. Out-of-range and misaligned fetches return a NOP word and raise a fault flag. It sits between the PC/fetch stage and the decode stage.

---
 rtl/imem_rom_ctl.sv | 134 +++++++++++++
 tb/tb_imem_rom_ctl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_rom_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imem_rom_ctl                                                 |
// | Description : Writable instruction memory with a registered, handshaked    |
// |               fetch port and a loader write port. After reset the array is |
// |               cleared to FILL_WORD, one word per cycle. Misaligned or      |
// |               out-of-range fetches return FILL_WORD with rsp_fault set.    |
// |               Misaligned or out-of-range loader writes are accepted and    |
// |               dropped.                                                     |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               req_valid/req_ready/req_addr   : fetch request              |
// |               rsp_valid/rsp_ready/rsp_data/rsp_fault : fetch response     |
// |               ld_valid/ld_ready/ld_addr/ld_data : loader write            |
// |               init_done : post-reset clear finished                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imem_rom_ctl #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 64,
  parameter logic [DATA_W-1:0]  FILL_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              init_done
);

  // DEPTH is a power of two, so a word index is in range exactly when every
  // address bit above the index field is zero. ADDR_W must exceed IDX_W+2.
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_clr_cnt;
  logic              r_init_done;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_fault;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]  w_req_idx;
  logic [IDX_W-1:0]  w_ld_idx;
  logic              w_req_ok;
  logic              w_ld_ok;
  logic              w_req_fire;
  logic              w_ld_fire;

  assign w_req_idx = req_addr[IDX_W+1:2];
  assign w_ld_idx  = ld_addr[IDX_W+1:2];
  assign w_req_ok  = (req_addr[1:0] == 2'b00) && (req_addr[ADDR_W-1:IDX_W+2] == '0);
  assign w_ld_ok   = (ld_addr[1:0] == 2'b00)  && (ld_addr[ADDR_W-1:IDX_W+2] == '0);

  // A full response register can take a new request in the cycle it drains.
  assign req_ready  = r_init_done && (!r_rsp_valid || rsp_ready);
  assign ld_ready   = r_init_done;
  assign init_done  = r_init_done;
  assign w_req_fire = req_valid && req_ready;
  assign w_ld_fire  = ld_valid && ld_ready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;

  // Clear sequencer. init_done is a registered copy of the RUN state, so it
  // rises one edge after the last word is written (edge DEPTH+1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_CLEAR;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_init_done <= 1'b0;
          r_clr_cnt   <= r_clr_cnt + IDX_W'(1);
          if (r_clr_cnt == c_last_idx) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_clr_cnt   <= '0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Word array. No reset: contents are defined by the clear sequence.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= FILL_WORD;
    end else if (w_ld_fire && w_ld_ok) begin
      r_mem[w_ld_idx] <= ld_data;
    end
  end

  // Response register. The array read samples the pre-edge contents, which
  // gives read-before-write on a same-cycle fetch/loader collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= FILL_WORD;
      r_rsp_fault <= 1'b0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_req_ok ? r_mem[w_req_idx] : FILL_WORD;
      r_rsp_fault <= !w_req_ok;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_rom_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_rom_ctl                                              |
// | Description : Scoreboard bench for imem_rom_ctl. Stimulus pushes expected  |
// |               responses; a negedge monitor pops them on each transfer.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_imem_rom_ctl;

  localparam logic [31:0] c_nop = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault;
  logic        ld_valid, ld_ready, init_done;
  logic [31:0] req_addr, ld_addr, ld_data, rsp_data;

  typedef struct packed {
    logic [31:0] d;
    logic        f;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [64];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          last_wait;
  int          n_init;

  always #5 clk = ~clk;

  imem_rom_ctl #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .FILL_WORD(32'h00000013)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fault(rsp_fault),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .init_done(init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer completes on the next edge when valid && ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got %h with no expected entry at %0t", rsp_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.f});
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] ed, input logic ef);
    int w;
    exp_q.push_back('{d: ed, f: ef});
    req_valid = 1'b1;
    req_addr  = a;
    w = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (req_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL fetch_accept: addr %h not accepted within %0d cycles", a, w);
    end
    last_wait = w;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic ldw(input logic [31:0] a, input logic [31:0] d);
    int w;
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    w = 0;
    @(negedge clk);
    while (ld_ready !== 1'b1 && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (ld_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ld_accept: addr %h not accepted within %0d cycles", a, w);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // Counts edges after reset release until init_done is seen high.
  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_addr = '0;
    ld_valid = 1'b0;  ld_addr = '0; ld_data = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 64; i++) mdl[i] = c_nop;

    // Reset state
    #12;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  rsp_data, c_nop);
    chk("rst_rsp_fault", {31'b0, rsp_fault}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_ld_ready",  {31'b0, ld_ready}, 32'd0);
    chk("rst_init_done", {31'b0, init_done}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n_init);
    chk("init_edges", n_init, 32'd65);
    chk("init_req_ready", {31'b0, req_ready}, 32'd1);
    chk("init_ld_ready",  {31'b0, ld_ready}, 32'd1);

    fetch(32'h0, c_nop, 1'b0);

    // Load program and fetch back to back
    ldw(32'h4, 32'h00800693); mdl[1] = 32'h00800693;
    ldw(32'h8, 32'h00D70023); mdl[2] = 32'h00D70023;
    ldw(32'hC, 32'h00071803); mdl[3] = 32'h00071803;
    fetch(32'h4, 32'h00800693, 1'b0); chk("b2b_wait0", last_wait, 32'd0);
    fetch(32'h8, 32'h00D70023, 1'b0); chk("b2b_wait1", last_wait, 32'd0);
    fetch(32'hC, 32'h00071803, 1'b0); chk("b2b_wait2", last_wait, 32'd0);

    // Faults; bad loader writes must not touch any word
    fetch(32'h6,   c_nop, 1'b1);
    fetch(32'h100, c_nop, 1'b1);
    ldw(32'h102, 32'h12345678);
    ldw(32'h6,   32'hCAFEF00D);
    for (int i = 0; i < 64; i++) fetch(32'(i * 4), mdl[i], 1'b0);

    // Backpressure
    repeat (3) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
    fetch(32'h4, mdl[1], 1'b0);
    exp_q.push_back('{d: mdl[2], f: 1'b0});
    req_valid = 1'b1;
    req_addr  = 32'h8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_data",  rsp_data, 32'h00800693);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Collision: same-cycle fetch and write to word 1
    exp_q.push_back('{d: mdl[1], f: 1'b0});
    req_valid = 1'b1; req_addr = 32'h4;
    ld_valid  = 1'b1; ld_addr  = 32'h4; ld_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("col_req_ready", {31'b0, req_ready}, 32'd1);
    chk("col_ld_ready",  {31'b0, ld_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    ld_valid  = 1'b0;
    mdl[1] = 32'hDEADBEEF;
    fetch(32'h4, 32'hDEADBEEF, 1'b0);

    ldw(32'hA0, 32'h55AA55AA);
    fetch(32'hA0, 32'h55AA55AA, 1'b0);

    // Reset with a pending response, then reset again mid-clear
    repeat (2) begin @(posedge clk); #1; end
    rsp_ready = 1'b0;
    fetch(32'h0, c_nop, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("prst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("prst_rsp_data",  rsp_data, c_nop);
    chk("prst_init_done", {31'b0, init_done}, 32'd0);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_init_done", {31'b0, init_done}, 32'd0);
    chk("mrst_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n_init);
    chk("mrst_init_edges", n_init, 32'd65);
    fetch(32'hA0, c_nop, 1'b0);
    fetch(32'h4,  c_nop, 1'b0);

    // Drain the scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
